// File: rtl/mips_defs.sv
// Shared encodings for the MIPS ALU issue controller: ALU operation codes, opcode/funct values
// and the sequencer state type.
package mips_defs;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [1:0] {StIdle, StDec, StExe, StWb} state_e;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational decode of one MIPS R/I-type word into ALU control, extended immediate and
// writeback destination.
module mips_instr_decode
  import mips_defs::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic [31:0]   instr,
  output logic [3:0]    alu_op,
  output logic          mux_sel,
  output logic [DW-1:0] imm_ext,
  output logic [RW-1:0] dest,
  output logic          wr_en,
  output logic          is_beq,
  output logic          illegal
);

  logic [5:0]    op;
  logic [5:0]    funct;
  logic [DW-1:0] imm_sext;
  logic [DW-1:0] imm_zext;

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign imm_sext = {{(DW-16){instr[15]}}, instr[15:0]};
  assign imm_zext = {{(DW-16){1'b0}}, instr[15:0]};

  always_comb begin
    alu_op  = AluAdd;
    mux_sel = 1'b0;
    imm_ext = '0;
    dest    = RW'(instr[20:16]);
    wr_en   = 1'b0;
    is_beq  = 1'b0;
    illegal = 1'b0;
    case (op)
      OpRtype: begin
        dest  = RW'(instr[15:11]);
        wr_en = 1'b1;
        case (funct)
          FnAdd:   alu_op = AluAdd;
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnNor:   alu_op = AluNor;
          FnSlt:   alu_op = AluSlt;
          default: begin
            illegal = 1'b1;
            wr_en   = 1'b0;
          end
        endcase
      end
      OpAddi: begin
        mux_sel = 1'b1;
        imm_ext = imm_sext;
        wr_en   = 1'b1;
      end
      OpSlti: begin
        alu_op  = AluSlt;
        mux_sel = 1'b1;
        imm_ext = imm_sext;
        wr_en   = 1'b1;
      end
      OpAndi: begin
        alu_op  = AluAnd;
        mux_sel = 1'b1;
        imm_ext = imm_zext;
        wr_en   = 1'b1;
      end
      OpOri: begin
        alu_op  = AluOr;
        mux_sel = 1'b1;
        imm_ext = imm_zext;
        wr_en   = 1'b1;
      end
      // Compare rs against rt; the immediate is the branch offset, not an ALU operand.
      OpBeq: begin
        alu_op  = AluSub;
        imm_ext = imm_sext;
        is_beq  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_alu_issue_ctrl.sv
// Issue/writeback sequencer for the regfile+ALU datapath: one instruction in flight through
// IDLE -> DEC -> EXE -> WB, with every output derived from registered state.
module mips_alu_issue_ctrl
  import mips_defs::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  output logic          instr_ready,
  output logic [RW-1:0] read_reg1,
  output logic [RW-1:0] read_reg2,
  output logic [3:0]    ALUop,
  output logic          MUXsel,
  output logic [DW-1:0] in1,
  input  logic [DW-1:0] ALUout,
  input  logic          ALUzero,
  output logic [RW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic          RegWrite,
  output logic          done,
  output logic          branch_taken,
  output logic          illegal
);

  state_e        state_q;
  logic [31:0]   instr_q;
  logic [DW-1:0] res_q;
  logic          zero_q;

  logic [3:0]    dec_alu_op;
  logic          dec_mux_sel;
  logic [DW-1:0] dec_imm;
  logic [RW-1:0] dec_dest;
  logic          dec_wr_en;
  logic          dec_is_beq;
  logic          dec_illegal;

  logic          issue;
  logic          wb;

  mips_instr_decode #(
    .DW (DW),
    .RW (RW)
  ) u_decode (
    .instr   (instr_q),
    .alu_op  (dec_alu_op),
    .mux_sel (dec_mux_sel),
    .imm_ext (dec_imm),
    .dest    (dec_dest),
    .wr_en   (dec_wr_en),
    .is_beq  (dec_is_beq),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= StDec;
          end
        end
        StDec:   state_q <= StExe;
        StExe: begin
          res_q   <= ALUout;
          zero_q  <= ALUzero;
          state_q <= StWb;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign issue = (state_q == StDec) || (state_q == StExe);
  assign wb    = (state_q == StWb);

  assign instr_ready = (state_q == StIdle);

  // Operand controls are held steady across DEC and EXE so the datapath settles before capture.
  assign read_reg1 = issue ? RW'(instr_q[25:21]) : '0;
  assign read_reg2 = issue ? RW'(instr_q[20:16]) : '0;
  assign ALUop     = issue ? dec_alu_op : '0;
  assign MUXsel    = issue & dec_mux_sel;
  assign in1       = issue ? dec_imm : '0;

  // Writeback qualifiers depend only on state_q, so an async reset drops them immediately.
  assign write_reg    = wb ? dec_dest : '0;
  assign write_data   = wb ? res_q : '0;
  assign RegWrite     = wb & dec_wr_en & (dec_dest != '0);
  assign done         = wb;
  assign branch_taken = wb & dec_is_beq & zero_q;
  assign illegal      = wb & dec_illegal;

endmodule

// File: tb/tb_mips_alu_issue_ctrl.sv
// Closed-loop bench: the issue controller drives a behavioural regfile+ALU datapath while an
// independent ISA model predicts each retirement into a scoreboard queue.
module tb_mips_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [3:0]  ALUop;
  logic        MUXsel, ALUzero, RegWrite, done, branch_taken, illegal;
  logic [31:0] in1, ALUout, write_data;

  always #5 clk = ~clk;

  mips_alu_issue_ctrl #(.DW(32), .RW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .ALUop        (ALUop),
    .MUXsel       (MUXsel),
    .in1          (in1),
    .ALUout       (ALUout),
    .ALUzero      (ALUzero),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .RegWrite     (RegWrite),
    .done         (done),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  // Behavioural datapath
  logic [31:0] dp_rf [32];
  logic        rf_clr;
  logic [31:0] alu_a, alu_b;

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) dp_rf[i] <= '0;
    end else if (RegWrite && write_reg != 5'd0) begin
      dp_rf[write_reg] <= write_data;
    end
  end

  always_comb begin
    alu_a = dp_rf[read_reg1];
    alu_b = MUXsel ? in1 : dp_rf[read_reg2];
    case (ALUop)
      4'b0000: ALUout = alu_a & alu_b;
      4'b0001: ALUout = alu_a | alu_b;
      4'b0010: ALUout = alu_a + alu_b;
      4'b0110: ALUout = alu_a - alu_b;
      4'b0111: ALUout = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: ALUout = ~(alu_a | alu_b);
      default: ALUout = '0;
    endcase
  end
  assign ALUzero = (ALUout == 32'd0);

  // Scoreboard and reference ISA state
  typedef struct packed {
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        br;
    logic        ill;
    logic [3:0]  aluop;
    logic        mux;
    logic [31:0] in1;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] ref_rf [32];
  int          n_vec = 0;
  int          n_err = 0;

  int          s_lat;
  logic        s_rw, s_br, s_ill, s_mux, s_post;
  logic [4:0]  s_wreg, s_rr1, s_rr2;
  logic [31:0] s_wdata, s_in1;
  logic [3:0]  s_aluop;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t predict(input logic [31:0] x);
    exp_t        e;
    logic [31:0] a, b, se, ze;
    a  = ref_rf[x[25:21]];
    b  = ref_rf[x[20:16]];
    se = {{16{x[15]}}, x[15:0]};
    ze = {16'h0000, x[15:0]};
    e  = '0;
    e.aluop = 4'b0010;
    case (x[31:26])
      6'h00: begin
        e.wreg = x[15:11];
        e.rw   = 1'b1;
        case (x[5:0])
          6'h20: e.wdata = a + b;
          6'h22: begin e.aluop = 4'b0110; e.wdata = a - b; end
          6'h24: begin e.aluop = 4'b0000; e.wdata = a & b; end
          6'h25: begin e.aluop = 4'b0001; e.wdata = a | b; end
          6'h27: begin e.aluop = 4'b1100; e.wdata = ~(a | b); end
          6'h2A: begin e.aluop = 4'b0111; e.wdata = {31'd0, $signed(a) < $signed(b)}; end
          default: begin e.ill = 1'b1; e.rw = 1'b0; end
        endcase
      end
      6'h08: begin e.wreg = x[20:16]; e.rw = 1'b1; e.mux = 1'b1; e.in1 = se; e.wdata = a + se; end
      6'h0A: begin
        e.wreg = x[20:16]; e.rw = 1'b1; e.mux = 1'b1; e.in1 = se; e.aluop = 4'b0111;
        e.wdata = {31'd0, $signed(a) < $signed(se)};
      end
      6'h0C: begin
        e.wreg = x[20:16]; e.rw = 1'b1; e.mux = 1'b1; e.in1 = ze; e.aluop = 4'b0000;
        e.wdata = a & ze;
      end
      6'h0D: begin
        e.wreg = x[20:16]; e.rw = 1'b1; e.mux = 1'b1; e.in1 = ze; e.aluop = 4'b0001;
        e.wdata = a | ze;
      end
      6'h04: begin e.aluop = 4'b0110; e.br = (a == b); end
      default: e.ill = 1'b1;
    endcase
    if (e.wreg == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  // Issue one instruction (called on a falling edge) and snapshot DEC and WB outputs.
  task automatic run_instr(input logic [31:0] x);
    int n = 0;
    sb.push_back(predict(x));
    instr_valid = 1'b1;
    instr       = x;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom;
    s_aluop = ALUop; s_mux = MUXsel; s_in1 = in1; s_rr1 = read_reg1; s_rr2 = read_reg2;
    s_lat = 1;
    while (!done && s_lat < 10) begin @(negedge clk); s_lat++; end
    s_rw = RegWrite; s_wreg = write_reg; s_wdata = write_data; s_br = branch_taken; s_ill = illegal;
    @(negedge clk);
    s_post = RegWrite | done;
    cur = sb.pop_front();
    if (cur.rw) ref_rf[cur.wreg] = cur.wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_clr = 1'b1; instr_valid = 1'b0; instr = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    repeat (2) @(negedge clk);
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++; if (ALUop !== 4'd0) begin n_err++; $display("FAIL reset_aluop: got %h want 0", ALUop); end
    n_vec++; if (in1 !== 32'd0) begin n_err++; $display("FAIL reset_in1: got %h want 0", in1); end
    rst = 1'b0; rf_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rtype();
    logic [31:0] prog [8];
    prog = '{enc_i(6'h08, 5'd0, 5'd1, 16'd5), enc_i(6'h08, 5'd0, 5'd2, 16'd7), 32'h00221820,
             enc_r(5'd2, 5'd1, 5'd8, 6'h22), enc_r(5'd1, 5'd2, 5'd9, 6'h24),
             enc_r(5'd1, 5'd2, 5'd10, 6'h25), enc_r(5'd1, 5'd2, 5'd11, 6'h27),
             enc_r(5'd1, 5'd2, 5'd12, 6'h2A)};
    for (int i = 0; i < 8; i++) begin
      run_instr(prog[i]);
      n_vec++; if (s_lat !== 3) begin n_err++; $display("FAIL r%0d_latency: got %0d want 3", i, s_lat); end
      n_vec++; if (s_rw !== cur.rw) begin n_err++; $display("FAIL r%0d_regwrite: got %b want %b", i, s_rw, cur.rw); end
      n_vec++; if (s_wreg !== cur.wreg) begin n_err++; $display("FAIL r%0d_write_reg: got %0d want %0d", i, s_wreg, cur.wreg); end
      n_vec++; if (s_wdata !== cur.wdata) begin n_err++; $display("FAIL r%0d_write_data: got %h want %h", i, s_wdata, cur.wdata); end
      n_vec++; if (s_aluop !== cur.aluop) begin n_err++; $display("FAIL r%0d_aluop: got %b want %b", i, s_aluop, cur.aluop); end
      n_vec++; if (s_mux !== cur.mux) begin n_err++; $display("FAIL r%0d_muxsel: got %b want %b", i, s_mux, cur.mux); end
      n_vec++; if (s_rr1 !== prog[i][25:21]) begin n_err++; $display("FAIL r%0d_read_reg1: got %0d want %0d", i, s_rr1, prog[i][25:21]); end
      n_vec++; if (s_post !== 1'b0) begin n_err++; $display("FAIL r%0d_strobe_width: got %b want 0", i, s_post); end
      if (i == 2) begin
        n_vec++; if (s_wdata !== 32'd12) begin n_err++; $display("FAIL add3_value: got %0d want 12", s_wdata); end
      end
    end
  endtask

  task automatic test_itype();
    logic [31:0] prog [4];
    prog = '{32'h2024FFFF, 32'h34058000, enc_i(6'h0C, 5'd2, 5'd13, 16'hFFFF),
             enc_i(6'h0A, 5'd1, 5'd14, 16'hFFFD)};
    for (int i = 0; i < 4; i++) begin
      run_instr(prog[i]);
      n_vec++; if (s_lat !== 3) begin n_err++; $display("FAIL i%0d_latency: got %0d want 3", i, s_lat); end
      n_vec++; if (s_mux !== 1'b1) begin n_err++; $display("FAIL i%0d_muxsel: got %b want 1", i, s_mux); end
      n_vec++; if (s_in1 !== cur.in1) begin n_err++; $display("FAIL i%0d_in1: got %h want %h", i, s_in1, cur.in1); end
      n_vec++; if (s_aluop !== cur.aluop) begin n_err++; $display("FAIL i%0d_aluop: got %b want %b", i, s_aluop, cur.aluop); end
      n_vec++; if (s_rw !== cur.rw) begin n_err++; $display("FAIL i%0d_regwrite: got %b want %b", i, s_rw, cur.rw); end
      n_vec++; if (s_wreg !== cur.wreg) begin n_err++; $display("FAIL i%0d_write_reg: got %0d want %0d", i, s_wreg, cur.wreg); end
      n_vec++; if (s_wdata !== cur.wdata) begin n_err++; $display("FAIL i%0d_write_data: got %h want %h", i, s_wdata, cur.wdata); end
    end
  endtask

  task automatic test_beq();
    logic [31:0] prog [2];
    logic        want [2];
    prog = '{enc_i(6'h04, 5'd1, 5'd1, 16'd3), enc_i(6'h04, 5'd1, 5'd2, 16'd3)};
    want = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      run_instr(prog[i]);
      n_vec++; if (s_br !== want[i]) begin n_err++; $display("FAIL beq%0d_taken: got %b want %b", i, s_br, want[i]); end
      n_vec++; if (s_br !== cur.br) begin n_err++; $display("FAIL beq%0d_model: got %b want %b", i, s_br, cur.br); end
      n_vec++; if (s_rw !== 1'b0) begin n_err++; $display("FAIL beq%0d_regwrite: got %b want 0", i, s_rw); end
      n_vec++; if (s_aluop !== 4'b0110) begin n_err++; $display("FAIL beq%0d_aluop: got %b want 0110", i, s_aluop); end
      n_vec++; if (s_lat !== 3) begin n_err++; $display("FAIL beq%0d_latency: got %0d want 3", i, s_lat); end
    end
  endtask

  task automatic test_zero_and_illegal();
    logic [31:0] prog [3];
    prog = '{32'h00220020, 32'hFC000000, enc_r(5'd1, 5'd2, 5'd3, 6'h03)};
    for (int i = 0; i < 3; i++) begin
      run_instr(prog[i]);
      n_vec++; if (s_lat !== 3) begin n_err++; $display("FAIL z%0d_latency: got %0d want 3", i, s_lat); end
      n_vec++; if (s_rw !== 1'b0) begin n_err++; $display("FAIL z%0d_regwrite: got %b want 0", i, s_rw); end
      n_vec++; if (s_ill !== cur.ill) begin n_err++; $display("FAIL z%0d_illegal: got %b want %b", i, s_ill, cur.ill); end
      n_vec++; if (s_aluop !== 4'b0010) begin n_err++; $display("FAIL z%0d_aluop: got %b want 0010", i, s_aluop); end
      n_vec++; if (s_mux !== 1'b0) begin n_err++; $display("FAIL z%0d_muxsel: got %b want 0", i, s_mux); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] i1, i2;
    int          cyc = 0, first = -1, second = -1, done1 = -1, t = 0;
    i1 = enc_r(5'd1, 5'd2, 5'd15, 6'h25);
    i2 = enc_i(6'h08, 5'd1, 5'd16, 16'd100);
    sb.push_back(predict(i1));
    instr_valid = 1'b1;
    instr       = i1;
    while (cyc < 20 && second < 0) begin
      if (instr_ready) begin
        if (first < 0) first = cyc; else second = cyc;
      end
      if (second < 0) begin
        @(negedge clk);
        cyc++;
        if (cyc == first + 1) begin instr = i2; sb.push_back(predict(i2)); end
        if (done) begin
          done1 = cyc;
          cur   = sb.pop_front();
          n_vec++; if (write_data !== cur.wdata) begin n_err++; $display("FAIL b2b_first_data: got %h want %h", write_data, cur.wdata); end
          if (cur.rw) ref_rf[cur.wreg] = cur.wdata;
        end
      end
    end
    n_vec++; if (second - first !== 4) begin n_err++; $display("FAIL b2b_spacing: got %0d want 4", second - first); end
    n_vec++; if (done1 - first !== 3) begin n_err++; $display("FAIL b2b_first_done: got %0d want 3", done1 - first); end
    @(negedge clk);
    instr_valid = 1'b0;
    while (!done && t < 10) begin @(negedge clk); t++; end
    cur = sb.pop_front();
    n_vec++; if (t !== 2) begin n_err++; $display("FAIL b2b_second_done: got %0d want 2", t); end
    n_vec++; if (write_data !== cur.wdata) begin n_err++; $display("FAIL b2b_second_data: got %h want %h", write_data, cur.wdata); end
    n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL b2b_second_regwrite: got %b want 1", RegWrite); end
    if (cur.rw) ref_rf[cur.wreg] = cur.wdata;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    instr_valid = 1'b1;
    instr       = enc_r(5'd1, 5'd2, 5'd6, 6'h20);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rstexe_ready: got %b want 1", instr_ready); end
    n_vec++; if (ALUop !== 4'd0) begin n_err++; $display("FAIL rstexe_aluop: got %b want 0", ALUop); end
    n_vec++; if (read_reg1 !== 5'd0) begin n_err++; $display("FAIL rstexe_read_reg1: got %0d want 0", read_reg1); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (dp_rf[6] !== 32'd0) begin n_err++; $display("FAIL rstexe_reg6: got %h want 0", dp_rf[6]); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rstexe_done: got %b want 0", done); end
    // Reset landing in WB must suppress the pending write.
    instr_valid = 1'b1;
    instr       = enc_r(5'd1, 5'd2, 5'd7, 6'h20);
    n = 0;
    @(negedge clk);
    instr_valid = 1'b0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    n_vec++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL rstwb_pre_regwrite: got %b want 1", RegWrite); end
    rst = 1'b1;
    #1;
    n_vec++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rstwb_regwrite: got %b want 0", RegWrite); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rstwb_done: got %b want 0", done); end
    n_vec++; if (write_data !== 32'd0) begin n_err++; $display("FAIL rstwb_write_data: got %h want 0", write_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (dp_rf[7] !== 32'd0) begin n_err++; $display("FAIL rstwb_reg7: got %h want 0", dp_rf[7]); end
    run_instr(enc_r(5'd1, 5'd2, 5'd6, 6'h20));
    n_vec++; if (s_wdata !== 32'd12) begin n_err++; $display("FAIL rst_recover_data: got %h want 12", s_wdata); end
  endtask

  task automatic test_regfile();
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      n_vec++;
      if (dp_rf[i] !== ref_rf[i]) begin
        n_err++; $display("FAIL regfile_r%0d: got %h want %h", i, dp_rf[i], ref_rf[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_beq();
    test_zero_and_illegal();
    test_back_to_back();
    test_reset_mid();
    test_regfile();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
